// File: rtl/apb_requester_if.sv
// apb_requester_if: client command/response signals plus the sel/enable/ready
// memory bus, bundled for the requester (master) and its environment (slave).
interface apb_requester_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);

  // client command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // client response channel
  logic              rsp_valid;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy;

  // responder bus
  logic              sel;
  logic              enable;
  logic              op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, ready, rdata,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata, busy,
           sel, enable, op, addr, wdata
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, ready, rdata,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata, busy,
           sel, enable, op, addr, wdata
  );

endinterface

// File: rtl/apb_requester.sv
// apb_requester: initiator for the sel/enable/ready bus. Takes one command at a
// time from the client, runs SETUP then ACCESS, waits for ready (bounded by
// TIMEOUT ACCESS cycles) and returns a single-cycle response. Because a new
// command is only taken in IDLE, sel always drops for at least one cycle between
// transfers, giving the responder a fresh rising edge on sel&enable.
module apb_requester #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  apb_requester_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  // ACCESS cycle number being completed at the coming edge
  assign count_next = count + CNT_ONE;

  // only IDLE takes commands; held low while reset is asserted
  assign bus.cmd_ready = (state == IDLE) && !rst;

  // transfer sequencer: IDLE -> SETUP -> ACCESS -> IDLE with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      bus.sel       <= 1'b0;
      bus.enable    <= 1'b0;
      bus.op        <= 1'b1;
      bus.addr      <= {ADDR_W{1'b0}};
      bus.wdata     <= {DATA_W{1'b0}};
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= {DATA_W{1'b0}};
      bus.busy      <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.op    <= bus.cmd_op;
            bus.addr  <= bus.cmd_addr;
            bus.wdata <= bus.cmd_wdata;
            bus.sel   <= 1'b1;
            bus.busy  <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          bus.enable <= 1'b1;
          count      <= '0;
          state      <= ACCESS;
        end
        ACCESS: begin
          if (bus.ready) begin
            bus.rsp_rdata <= bus.op ? bus.rdata : {DATA_W{1'b0}};
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.sel       <= 1'b0;
            bus.enable    <= 1'b0;
            bus.busy      <= 1'b0;
            count         <= '0;
            state         <= IDLE;
          end else if (count_next == CNT_LAST) begin
            bus.rsp_rdata <= {DATA_W{1'b0}};
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.sel       <= 1'b0;
            bus.enable    <= 1'b0;
            bus.busy      <= 1'b0;
            count         <= '0;
            state         <= IDLE;
          end else begin
            count <= count_next;
          end
        end
        default: begin
          bus.sel    <= 1'b0;
          bus.enable <= 1'b0;
          bus.busy   <= 1'b0;
          count      <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
